// File: rtl/serial_mmio.sv
// Serial window MMIO responder: CTRL/DATA/STATUS registers, TX and RX byte FIFOs,
// UART transmit start handshake and level interrupt.
module serial_mmio #(
   parameter int unsigned TX_AW     = 4,
   parameter int unsigned RX_AW     = 4,
   parameter int unsigned BUSY_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   input  logic        tx_busy_i,
   output logic        tx_start_o,
   output logic [7:0]  tx_data_o,
   output logic        int_o
);

   localparam int unsigned TX_DEPTH = 1 << TX_AW;
   localparam int unsigned RX_DEPTH = 1 << RX_AW;
   localparam int unsigned TPW      = TX_AW + 1;
   localparam int unsigned RPW      = RX_AW + 1;
   localparam int unsigned CW       = $clog2(BUSY_WAIT) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_DRAIN
   } tx_state_e;

   tx_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tx_start_q, tx_start_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic [TPW-1:0]   tx_wptr_q, tx_rptr_q;
   logic [RPW-1:0]   rx_wptr_q, rx_rptr_q;
   logic [7:0]       tx_mem_q [TX_DEPTH];
   logic [7:0]       rx_mem_q [RX_DEPTH];
   logic             ie_q, rx_ovr_q, tx_ovr_q, int_q;

   logic rd_c, wr_c, sel_ctrl_c, sel_data_c, sel_stat_c;
   logic tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
   logic tx_pop_c, tx_push_c, tx_ovr_set_c;
   logic rx_pop_c, rx_push_c, rx_ovr_set_c;
   logic [7:0]  rx_head_c;
   logic [31:0] status_c;
   logic        unused_c;

   assign unused_c = ^data_i[31:8];

   assign rd_c       = ce_i & ~we_i;
   assign wr_c       = ce_i & we_i;
   assign sel_ctrl_c = (addr_i == 4'h4);
   assign sel_data_c = (addr_i == 4'h8);
   assign sel_stat_c = (addr_i == 4'hC);

   // Full when pointers differ only in the extra MSB
   assign tx_empty_c = (tx_wptr_q == tx_rptr_q);
   assign tx_full_c  = ((tx_wptr_q ^ tx_rptr_q) == {1'b1, {TX_AW{1'b0}}});
   assign rx_empty_c = (rx_wptr_q == rx_rptr_q);
   assign rx_full_c  = ((rx_wptr_q ^ rx_rptr_q) == {1'b1, {RX_AW{1'b0}}});

   // A pop in the same cycle frees a slot, so the store/push is accepted
   assign tx_push_c    = wr_c & sel_data_c & (~tx_full_c | tx_pop_c);
   assign tx_ovr_set_c = wr_c & sel_data_c & tx_full_c & ~tx_pop_c;
   assign rx_pop_c     = rd_c & sel_data_c & ~rx_empty_c;
   assign rx_push_c    = rx_valid_i & (~rx_full_c | rx_pop_c);
   assign rx_ovr_set_c = rx_valid_i & rx_full_c & ~rx_pop_c;

   assign rx_head_c = rx_mem_q[rx_rptr_q[RX_AW-1:0]];
   assign status_c  = {28'h0, tx_ovr_q, rx_ovr_q, ~rx_empty_c, ~tx_full_c};

   // Load data mux
   always_comb begin
      data_o = 32'h0;
      if (rd_c) begin
         if (sel_ctrl_c)      data_o = {31'h0, ie_q};
         else if (sel_data_c) data_o = rx_empty_c ? 32'h0 : {24'h0, rx_head_c};
         else if (sel_stat_c) data_o = status_c;
      end
   end

   // TX FSM next-state and registered output values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_pop_c   = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if (~tx_empty_c & ~tx_busy_i) begin
               tx_pop_c   = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = tx_mem_q[tx_rptr_q[TX_AW-1:0]];
               cnt_d      = CW'(0);
               state_d    = ST_ARM;
            end
         end
         ST_ARM: begin
            if (tx_busy_i || (cnt_q == CW'(BUSY_WAIT - 1))) state_d = ST_DRAIN;
            else                                            cnt_d   = cnt_q + CW'(1);
         end
         ST_DRAIN: begin
            if (~tx_busy_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CW'(0);
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Pointers, control and sticky flags; set beats STATUS clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wptr_q <= TPW'(0);
         tx_rptr_q <= TPW'(0);
         rx_wptr_q <= RPW'(0);
         rx_rptr_q <= RPW'(0);
         ie_q      <= 1'b1;
         rx_ovr_q  <= 1'b0;
         tx_ovr_q  <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         if (tx_push_c) tx_wptr_q <= tx_wptr_q + TPW'(1);
         if (tx_pop_c)  tx_rptr_q <= tx_rptr_q + TPW'(1);
         if (rx_push_c) rx_wptr_q <= rx_wptr_q + RPW'(1);
         if (rx_pop_c)  rx_rptr_q <= rx_rptr_q + RPW'(1);
         if (wr_c & sel_ctrl_c) ie_q <= data_i[0];
         if (rx_ovr_set_c)              rx_ovr_q <= 1'b1;
         else if (rd_c & sel_stat_c)    rx_ovr_q <= 1'b0;
         if (tx_ovr_set_c)              tx_ovr_q <= 1'b1;
         else if (rd_c & sel_stat_c)    tx_ovr_q <= 1'b0;
         int_q <= ie_q & ~rx_empty_c;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push_c) tx_mem_q[tx_wptr_q[TX_AW-1:0]] <= data_i[7:0];
      if (rx_push_c) rx_mem_q[rx_wptr_q[RX_AW-1:0]] <= rx_data_i;
   end

   assign tx_start_o = tx_start_q;
   assign tx_data_o  = tx_data_q;
   assign int_o      = int_q;

endmodule

// File: doc/serial_mmio.md
Name: serial_mmio

Overview:
- Memory-mapped responder for the CPU data bus serial window.
- Accepts CPU loads and stores at byte offsets 0x4, 0x8 and 0xC.
- Buffers outgoing bytes in a TX FIFO and drives the UART transmitter start/data handshake.
- Buffers received bytes in an RX FIFO, exposes status, and raises a level interrupt to the CPU int_i vector.

Parameters:
- TX_AW, 4, log2 of TX FIFO depth (16 entries)
- RX_AW, 4, log2 of RX FIFO depth (16 entries)
- BUSY_WAIT, 8, max cycles in TX_ARM waiting for tx_busy_i to rise before giving up

Ports:
- clk  in  1  system clock; all state on posedge
- rst  in  1  asynchronous active-high reset
- ce_i  in  1  bus access to serial window this cycle
- we_i  in  1  1 = store, 0 = load
- addr_i  in  4  byte offset within window
- data_i  in  32  store data; only [7:0] used
- data_o  out  32  load data, combinational
- rx_valid_i  in  1  one-cycle pulse: new received byte, already in clk domain
- rx_data_i  in  8  received byte, valid with rx_valid_i
- tx_busy_i  in  1  transmitter busy level
- tx_start_o  out  1  registered transmit start pulse
- tx_data_o  out  8  registered byte to send, held from start until busy falls
- int_o  out  1  interrupt request, level

Behaviour:
- Reset: both FIFOs empty, pointers 0, tx_start_o=0, tx_data_o=0, overrun flags 0, ie=1, TX FSM=IDLE, int_o=0.
- Registers:
  - 0x4 CTRL (R/W): bit0 = ie.
  - 0x8 DATA: store pushes data_i[7:0] to TX FIFO; load returns {24'b0, RX head}.
  - 0xC STATUS (R): bit0 = TX not full, bit1 = RX not empty, bit2 = RX overrun, bit3 = TX overrun, rest 0.
  - Any other offset: loads read 0, stores ignored.
- data_o is combinational from current state when ce_i & ~we_i; 0 otherwise. Side effects happen at the posedge of that access cycle.
- DATA load:
  - RX non-empty: pop at the edge.
  - RX empty: returns 0, no pointer change.
- STATUS load: clears bits 2 and 3 at the edge. The returned value is the pre-clear value.
- Stores:
  - TX full: byte dropped, TX overrun set.
  - Store and TX pop in the same cycle with TX full: pop first, store accepted, no overrun.
- RX push on rx_valid_i:
  - RX full: byte dropped, RX overrun set.
  - Push and pop in the same cycle with RX full: both happen, no overrun.
  - Push and pop in the same cycle with RX empty: push only; the load returns 0.
- Overrun set and STATUS clear in the same cycle: set wins.
- Counts use AW+1-bit pointers.
  - Full when pointers differ only in MSB.
  - Empty when equal.
  - Wrap-around is natural modulo 2^(AW+1).
- TX FSM:
  - IDLE: if TX non-empty and ~tx_busy_i, pop head into tx_data_o, assert tx_start_o for 1 cycle, go ARM.
  - ARM: count cycles. Go DRAIN when tx_busy_i=1 or count=BUSY_WAIT-1.
  - DRAIN: go IDLE when tx_busy_i=0.
  - tx_start_o is high exactly the cycle after the IDLE decision. Minimum spacing between starts is 3 cycles.
- int_o = ie & RX not empty, registered (1-cycle lag).
- rst asserted mid-transfer: immediate return to reset values; queued bytes lost; tx_start_o drops at once.

Test Plan:
- Reset, then load 0xC → 0x00000001; load 0x8 → 0; int_o=0.
- Store 0x41, 0x42 to 0x8 with tx_busy_i modelled as 20 cycles high one cycle after start → two tx_start_o pulses, tx_data_o 0x41 then 0x42, second start only after busy falls.
- 17 rx_valid_i pulses with bytes 0x00..0x10, no reads → STATUS = 0x7. Sixteen DATA loads return 0x00..0x0F. Next STATUS = 0x1, overrun cleared.
- RX full plus rx_valid_i coinciding with DATA load → load returns the old head, new byte is stored, bit2 stays 0.
- Store 17 bytes while tx_busy_i held high → first 16 queued, bit3=1; release busy → 16 starts in order.
- ie=0 written to 0x4 with RX non-empty → int_o falls the next cycle. Assert rst during ARM → tx_start_o=0, STATUS=0x1, FSM restarts in IDLE.
